// File: rtl/ex_muldiv_seq_if.sv
// Handshake between the execute stage (master) and the multiply/divide sequencer (slave).
interface ex_muldiv_seq_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_i, flush_i,
        input  stall_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_i, flush_i,
        output stall_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer: 32 shift-add or restoring-divide
// iterations, stalling the front of the pipeline until the result is presented.
//
// state | meaning
// IDLE  | waiting for start_i; operands captured on acceptance
// RUN   | one iteration per cycle, cnt counts completed iterations
// DONE  | done_o high for one cycle with result_o/rd_o valid
module ex_muldiv_seq (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [32:0] acc;   // product high half for multiply, partial remainder R for divide
    logic [31:0] lo;    // product low half for multiply, quotient Q for divide
    logic [31:0] result_q;
    logic [4:0]  rd_out_q;
    logic        done_q;

    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [32:0] acc_nx;
    logic [31:0] lo_nx;
    logic [31:0] res_nx;

    always_comb begin
        mul_sum  = acc;
        if (lo[0]) begin
            mul_sum = acc + {1'b0, b_q};
        end
        div_sh   = {acc[31:0], lo[31]};
        div_diff = {1'b0, div_sh} - {2'b00, b_q};
        acc_nx   = {1'b0, mul_sum[32:1]};
        lo_nx    = {mul_sum[0], lo[31:1]};
        if (op_q[1]) begin
            if (!div_diff[33]) begin
                acc_nx = div_diff[32:0];
                lo_nx  = {lo[30:0], 1'b1};
            end else begin
                acc_nx = div_sh;
                lo_nx  = {lo[30:0], 1'b0};
            end
        end
        case (op_q)
            2'b00:   res_nx = lo_nx;
            2'b01:   res_nx = acc_nx[31:0];
            2'b10:   res_nx = lo_nx;
            default: res_nx = acc_nx[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            b_q      <= 32'd0;
            rd_q     <= 5'd0;
            cnt      <= 5'd0;
            acc      <= 33'd0;
            lo       <= 32'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q <= bus.op_i;
                        b_q  <= bus.b_i;
                        rd_q <= bus.rd_i;
                        cnt  <= 5'd0;
                        acc  <= 33'd0;
                        lo   <= bus.a_i;
                        // Divide by zero skips the loop: DIVU gives all ones, REMU gives the dividend.
                        if (bus.op_i[1] && (bus.b_i == 32'd0)) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            rd_out_q <= bus.rd_i;
                            result_q <= bus.op_i[0] ? bus.a_i : 32'hFFFF_FFFF;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        lo  <= lo_nx;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= res_nx;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational on start_i so the instruction holds in EX during its acceptance cycle.
    assign bus.stall_o  = ((state == IDLE) && bus.start_i && !bus.flush_i) || (state == RUN);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;
endmodule
